// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types and constants
package uart_pkg;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/uart_sync_edge.sv
// uart_sync_edge: N-flop synchronizers for the serial line and the oversample clock, plus tick edge detect
module uart_sync_edge #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    input  logic lvl_i,
    output logic rx_o,
    output logic tick_o
);
    logic [N-1:0] rx_q;
    logic [N-1:0] lvl_q;
    logic         prev_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_q   <= '1;
            lvl_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            rx_q   <= {rx_q[N-2:0], rx_i};
            lvl_q  <= {lvl_q[N-2:0], lvl_i};
            prev_q <= lvl_q[N-1];
        end
    end
    assign rx_o   = rx_q[N-1];
    assign tick_o = lvl_q[N-1] & ~prev_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 receiver with valid/ready holding register and framing/overrun flags
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bclk_x16,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun_err
);
    localparam int            TW   = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    rx_state_t                 state_q;
    logic [TW-1:0]             tick_q;
    logic [2:0]                bit_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q;
    logic                      busy_q;
    logic                      frame_q;
    logic                      overrun_q;
    logic                      rx_s;
    logic                      tick;
    uart_sync_edge #(.N(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .rx_i  (rx_in),
        .lvl_i (bclk_x16),
        .rx_o  (rx_s),
        .tick_o(tick)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            frame_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            frame_q   <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= state_q != IDLE;
            if (valid_q && rx_ready) valid_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    IDLE: if (!rx_s) begin
                        state_q <= START;
                        tick_q  <= '0;
                    end
                    START: begin
                        tick_q <= tick_q + 1'b1;
                        if (tick_q == MID) begin
                            tick_q  <= '0;
                            bit_q   <= '0;
                            state_q <= rx_s ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        tick_q <= tick_q + 1'b1;
                        if (tick_q == LAST) begin
                            tick_q  <= '0;
                            shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == 3'd7) state_q <= STOP;
                        end
                    end
                    STOP: begin
                        tick_q <= tick_q + 1'b1;
                        if (tick_q == LAST) begin
                            tick_q <= '0;
                            if (rx_s) begin
                                state_q <= IDLE;
                                // A same-cycle accept frees the register, so the new byte may replace the old one
                                if (!valid_q || rx_ready) begin
                                    data_q  <= shift_q;
                                    valid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end else begin
                                frame_q <= 1'b1;
                                state_q <= BREAK;
                            end
                        end
                    end
                    BREAK: if (rx_s) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign rx_busy     = busy_q;
    assign frame_err   = frame_q;
    assign overrun_err = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx framing, handshake, errors and reset
module tb_uart_rx;
    localparam int BIT = 64;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bclk_x16 = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         ov_cyc = 0;
    int         rise_cyc = 0;
    int         vlow_cnt = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] xq[$];

    uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .bclk_x16   (bclk_x16),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    // Oversample clock: one rising edge every 4 clk, so one bit is 64 clk
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        bclk_x16 <= cyc[1];
    end

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun_err) begin
            ov_cnt++;
            ov_cyc = cyc;
        end
        if (rx_valid && !valid_prev) rise_cyc = cyc;
        if (!rx_valid) vlow_cnt++;
        if (rx_valid && rx_ready) xq.push_back(rx_data);
        valid_prev = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic align();
        while (cyc % 4 != 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        align();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        int s, d, fe0, ov0, xn0, vl0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {rx_data, rx_valid, rx_busy, frame_err, overrun_err}, 0);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        fe0 = fe_cnt; ov0 = ov_cnt; xn0 = xq.size();
        align();
        s = cyc;
        send_frame(8'h55, 1'b1);
        check("t1_valid", rx_valid, 1);
        check("t1_data", rx_data, 8'h55);
        check("t1_latency", (rise_cyc - s >= 600) && (rise_cyc - s <= 624), 1);
        check("t1_busy_idle", rx_busy, 0);
        check("t1_errors", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        pulse_ready();
        check("t1_cleared", rx_valid, 0);
        check("t1_xfer_count", xq.size() - xn0, 1);
        check("t1_xfer_data", xq[xn0], 8'h55);

        fe0 = fe_cnt; ov0 = ov_cnt; xn0 = xq.size();
        rx_ready = 1'b1;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rx_ready = 1'b0;
        check("t2_xfer_count", xq.size() - xn0, 2);
        check("t2_first", xq[xn0], 8'hA3);
        check("t2_second", xq[xn0+1], 8'h0F);
        check("t2_errors", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        check("t2_valid_clear", rx_valid, 0);

        fe0 = fe_cnt; ov0 = ov_cnt;
        align();
        rx_in = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("t3_busy_glitch", rx_busy, 1);
        rx_in = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        #1;
        check("t3_idle", rx_busy, 0);
        check("t3_no_valid", rx_valid, 0);
        check("t3_errors", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        send_frame(8'h3C, 1'b1);
        check("t3_valid", rx_valid, 1);
        check("t3_data", rx_data, 8'h3C);
        pulse_ready();

        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h81, 1'b0);
        rx_in = 1'b0;
        repeat (30 * BIT) @(posedge clk);
        #1;
        check("t4_busy_break", rx_busy, 1);
        check("t4_one_ferr", fe_cnt - fe0, 1);
        check("t4_no_valid", rx_valid, 0);
        rx_in = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        #1;
        check("t4_idle", rx_busy, 0);
        send_frame(8'h7E, 1'b1);
        check("t4_valid", rx_valid, 1);
        check("t4_data", rx_data, 8'h7E);
        check("t4_ferr_total", fe_cnt - fe0, 1);
        check("t4_no_overrun", ov_cnt - ov0, 0);
        pulse_ready();

        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        align();
        s = cyc;
        send_frame(8'h22, 1'b1);
        d = ov_cyc - s;
        check("t5_one_overrun", ov_cnt - ov0, 1);
        check("t5_overrun_time", (d >= 600) && (d <= 624), 1);
        check("t5_valid_kept", rx_valid, 1);
        check("t5_data_kept", rx_data, 8'h11);
        ov0 = ov_cnt; xn0 = xq.size();
        align();
        vl0 = vlow_cnt;
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (d - 1) @(posedge clk);
                #1;
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
            end
        join
        check("t5_no_overrun", ov_cnt - ov0, 0);
        check("t5_valid_held", vlow_cnt - vl0, 0);
        check("t5_old_xfer_count", xq.size() - xn0, 1);
        check("t5_old_xfer_data", xq[xn0], 8'h11);
        check("t5_new_data", rx_data, 8'h22);
        pulse_ready();

        fe0 = fe_cnt; ov0 = ov_cnt; xn0 = xq.size();
        align();
        fork
            send_frame(8'hC5, 1'b1);
            begin
                repeat (5 * BIT + 32) @(posedge clk);
                #1;
                check("t6_busy_mid", rx_busy, 1);
                reset = 1'b0;
                #1;
                check("t6_async_reset", {rx_data, rx_valid, rx_busy, frame_err, overrun_err}, 0);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (BIT) @(posedge clk);
        #1;
        check("t6_after_release", {rx_valid, rx_busy}, 0);
        send_frame(8'h5A, 1'b1);
        check("t6_valid", rx_valid, 1);
        check("t6_data", rx_data, 8'h5A);
        check("t6_errors", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        check("t6_no_xfer", xq.size() - xn0, 0);
        pulse_ready();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
